// File: rtl/cpu24_pkg.sv
// cpu24_pkg: shared encodings, field positions and types for the cpu24 control sequencer
package cpu24_pkg;

   localparam int INSTR_W = 24;
   localparam int OP_HI   = 23;
   localparam int OP_LO   = 20;
   localparam int FN_HI   = 3;
   localparam int FN_LO   = 0;

   localparam logic [3:0] OP_ADDI = 4'b0001;
   localparam logic [3:0] OP_LS   = 4'b0010;
   localparam logic [3:0] OP_SS   = 4'b0011;
   localparam logic [3:0] OP_BEQ  = 4'b0100;
   localparam logic [3:0] OP_R    = 4'b0110;
   localparam logic [3:0] FN_CMP  = 4'b0101;

   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;
   localparam logic [1:0] ALU_CMP   = 2'b11;

   typedef enum logic [2:0] {
      ST_FETCH,
      ST_DECODE,
      ST_EXEC,
      ST_MEM,
      ST_WB,
      ST_TRAP
   } state_t;

   typedef enum logic [2:0] {
      CL_ADDI,
      CL_LS,
      CL_SS,
      CL_BEQ,
      CL_R,
      CL_CMP,
      CL_ILLEGAL
   } iclass_t;

endpackage

// File: rtl/cpu24_decode.sv
// cpu24_decode: combinational opcode/funct classifier feeding the sequencer FSM
module cpu24_decode
   import cpu24_pkg::*;
(
   input  logic [3:0] opcode,
   input  logic [3:0] funct,
   output iclass_t    iclass
);

   // R-type splits into CMP (no writeback) and ordinary R on funct
   always_comb begin
      iclass = (opcode == OP_ADDI) ? CL_ADDI :
               (opcode == OP_LS)   ? CL_LS   :
               (opcode == OP_SS)   ? CL_SS   :
               (opcode == OP_BEQ)  ? CL_BEQ  :
               (opcode == OP_R)    ? ((funct == FN_CMP) ? CL_CMP : CL_R) :
                                     CL_ILLEGAL;
   end

endmodule

// File: rtl/cpu24_sequencer.sv
// cpu24_sequencer: multicycle fetch/decode/exec/mem/wb control FSM with memory handshakes and traps
module cpu24_sequencer
   import cpu24_pkg::*;
#(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 16
) (
   input  logic               Clock,
   input  logic               Reset_n,
   input  logic [INSTR_W-1:0] Instr,
   input  logic               IMemAck,
   input  logic               DMemAck,
   input  logic               Zero,
   output logic               IMemReq,
   output logic               DMemReq,
   output logic               MemRead,
   output logic               MemWrite,
   output logic [INSTR_W-1:0] IR,
   output logic               IRWrite,
   output logic               PCWrite,
   output logic               PCSrc,
   output logic               RegWrite,
   output logic               RegDst,
   output logic               MemToReg,
   output logic               AluSrc,
   output logic [1:0]         AluOp,
   output logic               Halted,
   output logic               BusErr,
   output logic               Illegal,
   output logic [CNT_W-1:0]   Retired
);

   localparam int WAIT_W = $clog2(TIMEOUT + 1);

   state_t            state;
   state_t            next;
   iclass_t           iclass;
   logic [WAIT_W-1:0] wait_cnt;
   logic              timed_out;
   logic              set_illegal;
   logic              set_buserr;
   logic              retire;

   cpu24_decode u_decode (
      .opcode (IR[OP_HI:OP_LO]),
      .funct  (IR[FN_HI:FN_LO]),
      .iclass (iclass)
   );

   assign timed_out = (wait_cnt == WAIT_W'(TIMEOUT - 1));
   assign retire    = (next == ST_FETCH) && (state == ST_EXEC || state == ST_MEM || state == ST_WB);
   assign Halted    = (state == ST_TRAP);

   // state, IR, ack-wait counter, sticky trap flags and retire counter
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         state    <= ST_FETCH;
         IR       <= '0;
         wait_cnt <= '0;
         BusErr   <= 1'b0;
         Illegal  <= 1'b0;
         Retired  <= '0;
      end else begin
         state    <= next;
         if (IRWrite) IR <= Instr;
         wait_cnt <= (next == state && (state == ST_FETCH || state == ST_MEM)) ? wait_cnt + 1'b1 : '0;
         if (set_buserr) BusErr <= 1'b1;
         if (set_illegal) Illegal <= 1'b1;
         if (retire) Retired <= Retired + CNT_W'(1);
      end
   end

   // next state and Mealy datapath controls; an ack on the timeout cycle wins over the trap
   always_comb begin
      next        = state;
      IMemReq     = 1'b0;
      DMemReq     = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      PCWrite     = 1'b0;
      PCSrc       = 1'b0;
      RegWrite    = 1'b0;
      RegDst      = 1'b0;
      MemToReg    = 1'b0;
      AluSrc      = 1'b0;
      AluOp       = ALU_ADD;
      set_illegal = 1'b0;
      set_buserr  = 1'b0;
      case (state)
         ST_FETCH: begin
            IMemReq = 1'b1;
            if (IMemAck) begin
               IRWrite = 1'b1;
               PCWrite = 1'b1;
               next    = ST_DECODE;
            end else if (timed_out) begin
               set_buserr = 1'b1;
               next       = ST_TRAP;
            end
         end
         ST_DECODE: begin
            set_illegal = (iclass == CL_ILLEGAL);
            next        = (iclass == CL_ILLEGAL) ? ST_TRAP : ST_EXEC;
         end
         ST_EXEC: begin
            case (iclass)
               CL_ADDI: begin
                  AluSrc = 1'b1;
                  next   = ST_WB;
               end
               CL_LS, CL_SS: begin
                  AluSrc = 1'b1;
                  next   = ST_MEM;
               end
               CL_BEQ: begin
                  AluOp   = ALU_SUB;
                  PCSrc   = 1'b1;
                  PCWrite = Zero;
                  next    = ST_FETCH;
               end
               CL_R: begin
                  AluOp = ALU_FUNCT;
                  next  = ST_WB;
               end
               CL_CMP: begin
                  AluOp = ALU_CMP;
                  next  = ST_FETCH;
               end
               default: next = ST_TRAP;
            endcase
         end
         ST_MEM: begin
            DMemReq  = 1'b1;
            MemRead  = (iclass == CL_LS);
            MemWrite = (iclass == CL_SS);
            if (DMemAck) begin
               next = (iclass == CL_LS) ? ST_WB : ST_FETCH;
            end else if (timed_out) begin
               set_buserr = 1'b1;
               next       = ST_TRAP;
            end
         end
         ST_WB: begin
            RegWrite = 1'b1;
            RegDst   = (iclass == CL_R);
            MemToReg = (iclass == CL_LS);
            next     = ST_FETCH;
         end
         default: next = ST_TRAP;
      endcase
   end

endmodule
